// File: rtl/line_window_fetch.sv
// Builds the four 9-cell line windows (row, column, diagonal, anti-diagonal) around a
// board position by reading the board RAM one cell per cycle. Optional macro: LINE_WINDOW_EDGE_BLOCK_EN.
module line_window_fetch #(
    parameter int unsigned BOARD_N = 15
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [3:0] i_row,
    input  logic [3:0] i_col,
    output logic       o_rd_en,
    output logic [7:0] o_rd_addr,
    input  logic [1:0] i_rd_data,
    output logic [8:0] o_a,
    output logic [8:0] o_b,
    output logic [1:0] o_win_dir,
    output logic       o_win_valid,
    output logic       o_busy,
    output logic       o_done
);

    localparam int unsigned LAST_ISSUE = 35;
    localparam int unsigned LAST_CAP   = 36;
    localparam int unsigned LAST_CYC   = 37;
    localparam logic signed [5:0] COORD_MAX = 6'(BOARD_N - 1);

`ifdef LINE_WINDOW_EDGE_BLOCK_EN
    localparam logic EDGE_B = 1'b1;
`else
    localparam logic EDGE_B = 1'b0;
`endif

    typedef enum logic {
        S_IDLE,
        S_FETCH
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [5:0] r_cnt;
    logic [3:0] r_row;
    logic [3:0] r_col;
    logic [3:0] r_iss_k;
    logic [1:0] r_iss_d;
    logic [3:0] r_cap_k;
    logic [1:0] r_cap_d;
    logic       r_off;
    logic       r_off_d;
    logic [7:0] r_stg_a;
    logic [7:0] r_stg_b;

    logic              w_accept;
    logic              w_iss_go;
    logic              w_cap;
    logic [3:0]        w_nk;
    logic [1:0]        w_nd;
    logic [3:0]        w_base_row;
    logic [3:0]        w_base_col;
    logic signed [5:0] w_off;
    logic signed [5:0] w_r;
    logic signed [5:0] w_c;
    logic              w_offbrd;
    logic [7:0]        w_addr;
    logic              w_bit_a;
    logic              w_bit_b;

    assign w_accept = (r_state == S_IDLE) && i_start &&
                      (i_row <= 4'(BOARD_N - 1)) && (i_col <= 4'(BOARD_N - 1));
    assign w_iss_go = w_accept || ((r_state == S_FETCH) && (r_cnt < 6'(LAST_ISSUE)));
    assign w_cap    = (r_state == S_FETCH) && (r_cnt >= 6'd1) && (r_cnt <= 6'(LAST_CAP));
    assign o_busy   = (r_state == S_FETCH);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_FETCH;
            S_FETCH: if (r_cnt == 6'(LAST_CYC)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next slot to issue: the first slot comes straight from the request ports.
    always_comb begin
        w_nk       = '0;
        w_nd       = '0;
        w_base_row = r_row;
        w_base_col = r_col;
        if (w_accept) begin
            w_base_row = i_row;
            w_base_col = i_col;
        end else if (r_iss_k == 4'd8) begin
            w_nd = r_iss_d + 2'd1;
        end else begin
            w_nk = r_iss_k + 4'd1;
            w_nd = r_iss_d;
        end
    end

    always_comb begin
        w_off = $signed({2'b00, w_nk}) - 6'sd4;
        w_r   = $signed({2'b00, w_base_row});
        w_c   = $signed({2'b00, w_base_col});
        case (w_nd)
            2'd0: w_c = w_c + w_off;
            2'd1: w_r = w_r + w_off;
            2'd2: begin
                w_r = w_r + w_off;
                w_c = w_c + w_off;
            end
            default: begin
                w_r = w_r + w_off;
                w_c = w_c - w_off;
            end
        endcase
        w_offbrd = (w_r < 6'sd0) || (w_r > COORD_MAX) || (w_c < 6'sd0) || (w_c > COORD_MAX);
        w_addr   = 8'(w_r[3:0]) * 8'(BOARD_N) + 8'(w_c[3:0]);
    end

    assign w_bit_a = r_off_d ? 1'b0   : (i_rd_data == 2'b01);
    assign w_bit_b = r_off_d ? EDGE_B : (i_rd_data == 2'b10);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_iss_k     <= '0;
            r_iss_d     <= '0;
            r_cap_k     <= '0;
            r_cap_d     <= '0;
            r_off       <= 1'b0;
            r_off_d     <= 1'b0;
            r_stg_a     <= '0;
            r_stg_b     <= '0;
            o_rd_en     <= 1'b0;
            o_rd_addr   <= '0;
            o_a         <= '0;
            o_b         <= '0;
            o_win_dir   <= '0;
            o_win_valid <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_win_valid <= 1'b0;
            o_done      <= 1'b0;
            r_off_d     <= r_off;

            if (w_accept) begin
                r_row   <= i_row;
                r_col   <= i_col;
                r_cnt   <= '0;
                r_cap_k <= '0;
                r_cap_d <= '0;
            end else if ((r_state == S_FETCH) && (r_cnt != 6'(LAST_CYC))) begin
                r_cnt <= r_cnt + 6'd1;
            end

            // Off-board cells still take a slot so scan length never depends on position.
            if (w_iss_go) begin
                r_iss_k   <= w_nk;
                r_iss_d   <= w_nd;
                r_off     <= w_offbrd;
                o_rd_en   <= ~w_offbrd;
                o_rd_addr <= w_offbrd ? 8'd0 : w_addr;
            end else begin
                r_off     <= 1'b0;
                o_rd_en   <= 1'b0;
                o_rd_addr <= '0;
            end

            if (w_cap) begin
                if (r_cap_k == 4'd8) begin
                    o_a         <= {w_bit_a, r_stg_a};
                    o_b         <= {w_bit_b, r_stg_b};
                    o_win_dir   <= r_cap_d;
                    o_win_valid <= 1'b1;
                    o_done      <= (r_cap_d == 2'd3);
                    r_cap_k     <= '0;
                    r_cap_d     <= r_cap_d + 2'd1;
                end else begin
                    r_stg_a[r_cap_k[2:0]] <= w_bit_a;
                    r_stg_b[r_cap_k[2:0]] <= w_bit_b;
                    r_cap_k               <= r_cap_k + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_window_fetch.sv
// Bench for line_window_fetch: board RAM responder plus a coordinate-level window model.
module tb_line_window_fetch;

`ifdef LINE_WINDOW_EDGE_BLOCK_EN
    localparam bit EDGE_B = 1'b1;
`else
    localparam bit EDGE_B = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] row_in;
    logic [3:0] col_in;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic [1:0] rd_data = 2'b00;
    logic [8:0] a_out;
    logic [8:0] b_out;
    logic [1:0] win_dir;
    logic       win_valid;
    logic       busy;
    logic       done;

    logic [1:0] mem [256];
    int n_cmp = 0;
    int n_bad = 0;

    int         dr [4] = '{0, 1, 1, 1};
    int         dc [4] = '{1, 0, 1, -1};
    logic [8:0] exp_a [4];
    logic [8:0] exp_b [4];
    int         exp_addr [36];
    int         exp_rd;
    logic [8:0] last_a [4];
    logic [8:0] last_b [4];
    int         last_rd;

    line_window_fetch #(.BOARD_N(15)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_row      (row_in),
        .i_col      (col_in),
        .o_rd_en    (rd_en),
        .o_rd_addr  (rd_addr),
        .i_rd_data  (rd_data),
        .o_a        (a_out),
        .o_b        (b_out),
        .o_win_dir  (win_dir),
        .o_win_valid(win_valid),
        .o_busy     (busy),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    // RAM with one-cycle read latency; junk on the bus when no read is issued.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        else       rd_data <= 2'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < 256; i++) mem[i] = 2'b00;
    endtask

    task automatic random_board();
        for (int i = 0; i < 256; i++) mem[i] = 2'($urandom_range(0, 3));
    endtask

    // Windows straight from board coordinates: cell (row+k*dr, col+k*dc), k=-4..4 -> bit k+4.
    task automatic model(input int r0, input int c0);
        int r, c, s;
        exp_rd = 0;
        for (int d = 0; d < 4; d++) begin
            exp_a[d] = '0;
            exp_b[d] = '0;
            for (int j = 0; j < 9; j++) begin
                r = r0 + (j - 4) * dr[d];
                c = c0 + (j - 4) * dc[d];
                s = 9 * d + j;
                if (r < 0 || r > 14 || c < 0 || c > 14) begin
                    exp_addr[s] = -1;
                    exp_b[d][j] = EDGE_B;
                end else begin
                    exp_addr[s] = r * 15 + c;
                    exp_rd++;
                    exp_a[d][j] = (mem[r * 15 + c] == 2'b01);
                    exp_b[d][j] = (mem[r * 15 + c] == 2'b10);
                end
            end
        end
    endtask

    task automatic run_scan(input int r0, input int c0, input int dup_at, input string nm);
        int   nv, rd_cnt, done_cnt, done_cyc, max_addr;
        int   oc [4];
        int   od [4];
        bit   busy_ok, addr_ok, exp_en;
        model(r0, c0);
        nv = 0; rd_cnt = 0; done_cnt = 0; done_cyc = -1; max_addr = 0;
        busy_ok = 1'b1; addr_ok = 1'b1;
        for (int d = 0; d < 4; d++) begin
            oc[d] = -1; od[d] = -1; last_a[d] = 'x; last_b[d] = 'x;
        end
        @(negedge clk);
        start  = 1'b1;
        row_in = 4'(r0);
        col_in = 4'(c0);
        for (int cyc = 0; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 0) start = 1'b0;
            if (win_valid) begin
                if (nv < 4) begin
                    oc[nv] = cyc; od[nv] = int'(win_dir);
                    last_a[nv] = a_out; last_b[nv] = b_out;
                end
                nv++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (rd_en) begin
                rd_cnt++;
                if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
            end
            if (busy !== (cyc <= 37)) busy_ok = 1'b0;
            exp_en = (cyc <= 35) && (exp_addr[cyc > 35 ? 0 : cyc] >= 0);
            if (rd_en !== exp_en) addr_ok = 1'b0;
            else if (exp_en && rd_addr !== 8'(exp_addr[cyc])) addr_ok = 1'b0;
            else if (!exp_en && rd_addr !== 8'd0) addr_ok = 1'b0;
            if (cyc == dup_at) begin
                start  = 1'b1;
                row_in = 4'($urandom_range(0, 14));
                col_in = 4'($urandom_range(0, 14));
            end else if (cyc == dup_at + 1) begin
                start = 1'b0;
            end
        end
        last_rd = rd_cnt;
        check({nm, "_nwin"}, nv, 4);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("%s_w%0d_cyc", nm, d), oc[d], 9 * d + 10);
            check($sformatf("%s_w%0d_dir", nm, d), od[d], d);
            check($sformatf("%s_w%0d_a", nm, d), 32'(last_a[d]), 32'(exp_a[d]));
            check($sformatf("%s_w%0d_b", nm, d), 32'(last_b[d]), 32'(exp_b[d]));
        end
        check({nm, "_done_cnt"}, done_cnt, 1);
        check({nm, "_done_cyc"}, done_cyc, 37);
        check({nm, "_rd_cnt"}, rd_cnt, exp_rd);
        check({nm, "_busy"}, 32'(busy_ok), 1);
        check({nm, "_rd_seq"}, 32'(addr_ok), 1);
        check({nm, "_max_addr_ok"}, 32'(max_addr <= 224), 1);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_a"}, 32'(a_out), 0);
        check({nm, "_b"}, 32'(b_out), 0);
        check({nm, "_dir"}, 32'(win_dir), 0);
        check({nm, "_valid"}, 32'(win_valid), 0);
        check({nm, "_busy"}, 32'(busy), 0);
        check({nm, "_done"}, 32'(done), 0);
        check({nm, "_rd_en"}, 32'(rd_en), 0);
        check({nm, "_rd_addr"}, 32'(rd_addr), 0);
    endtask

    initial begin
        int nv, nbusy;
        rst = 1'b1; start = 1'b0; row_in = '0; col_in = '0;
        clear_board();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Empty board, centre.
        run_scan(7, 7, -1, "empty77");

        // Four blacks and a white on row 7.
        for (int c = 5; c <= 8; c++) mem[7 * 15 + c] = 2'b01;
        mem[7 * 15 + 9] = 2'b10;
        run_scan(7, 7, -1, "pat77");
        check("pat77_d0_a_const", 32'(last_a[0]), 32'(9'b000111100));
        check("pat77_d0_b_const", 32'(last_b[0]), 32'(9'b001000000));
        check("pat77_d2_a_const", 32'(last_a[2]), 32'(9'b000010000));

        // Reset in cycle 15 of a scan, with a non-zero window already on the outputs.
        @(negedge clk);
        start = 1'b1; row_in = 4'd7; col_in = 4'd7;
        for (int cyc = 0; cyc <= 15; cyc++) begin
            @(negedge clk);
            if (cyc == 0) start = 1'b0;
        end
        check("midrst_pre_a", 32'(a_out), 32'(9'b000111100));
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        nv = 0; nbusy = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (win_valid) nv++;
            if (busy) nbusy++;
        end
        check("midrst_no_win", nv, 0);
        check("midrst_no_busy", nbusy, 0);
        run_scan(7, 7, -1, "after_rst");

        // Corner on an empty board.
        clear_board();
        run_scan(0, 0, -1, "corner00");
        check("corner00_rd16", last_rd, 16);
        check("corner00_d0_b_const", 32'(last_b[0]), EDGE_B ? 32'(9'b000001111) : 32'd0);
        check("corner00_d3_b_const", 32'(last_b[3]), EDGE_B ? 32'(9'b111101111) : 32'd0);

        // Requests outside the board are dropped.
        @(negedge clk);
        start = 1'b1; row_in = 4'd3; col_in = 4'd15;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (busy || rd_en) nbusy++;
        end
        check("bad_col_idle", nbusy, 0);
        @(negedge clk);
        start = 1'b1; row_in = 4'd15; col_in = 4'd2;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("bad_row_idle", 32'(busy), 0);

        // A second request mid-scan must not disturb the scan in progress.
        random_board();
        run_scan(7, 7, 5, "dup_start");

        // Random boards and positions, plus the other corners.
        for (int t = 0; t < 6; t++) begin
            random_board();
            run_scan($urandom_range(0, 14), $urandom_range(0, 14), -1, $sformatf("rnd%0d", t));
        end
        random_board();
        run_scan(14, 14, -1, "corner1414");
        run_scan(0, 14, -1, "corner0014");
        run_scan(14, 0, -1, "corner1400");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/line_window_fetch.md
# line_window_fetch

Upstream feeder for `judgeChessForm` in the gobang evaluator. Given a candidate board position, it reads the 15×15 board RAM cell by cell and assembles the four 9-cell line windows (horizontal, vertical, diagonal, anti-diagonal) centred on that position. Each window is presented as the A (black) and B (white) 9-bit occupancy masks that `judgeChessForm` classifies into a `typeOut` pattern.

## Interface
- `BOARD_N`, 15, board side length; addresses are `row*BOARD_N+col`, range 0..224.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to scan the position at `row`,`col`.
- `row`  in  4  centre row, 0..14.
- `col`  in  4  centre column, 0..14.
- `rd_en`  out  1  board RAM read strobe.
- `rd_addr`  out  8  board RAM address.
- `rd_data`  in  2  cell contents, valid the cycle after `rd_en`: 00 empty, 01 black, 10 white, 11 treated as empty.
- `A`  out  9  black-stone mask of the current window.
- `B`  out  9  white-stone mask of the current window (also carries edge blocking, see Configuration).
- `win_dir`  out  2  window direction: 0 = (0,+1), 1 = (+1,0), 2 = (+1,+1), 3 = (+1,−1) as (drow,dcol).
- `win_valid`  out  1  one-cycle pulse; `A`/`B`/`win_dir` hold a new window.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse coinciding with the direction-3 `win_valid`.

## Operation
- States: IDLE, FETCH.
- **IDLE.** `start`=1 with `row`≤14 and `col`≤14:
  - latch `row`/`col`;
  - go to FETCH with slot counter s=0.
- **Ignored starts.** `start` is ignored when:
  - `row` or `col` > 14;
  - the block is already busy.
- **FETCH.** One slot per cycle, s = 0..35.
  - d = s/9, k = (s mod 9) − 4.
  - Cell = (`row`+k·drow_d, `col`+k·dcol_d).
- **On-board cell.**
  - `rd_en`=1.
  - `rd_addr` = cell address, computed as 8-bit unsigned with no overflow.
- **Off-board cell** (any coordinate <0 or >14):
  - `rd_en`=0, `rd_addr`=0;
  - a tag bit is pipelined alongside the slot.
- **Capture.** One cycle later, the cell result is shifted into bit (k+4) of the staging masks. Bit 4 is the centre, bit 0 is offset −4, bit 8 is offset +4.
- **Window completion.** When slot 9d+8 is captured, the staging masks are copied to `A`/`B`, `win_dir`=d, and `win_valid` pulses.
- **End of scan.** After slot 35 is captured, the block returns to IDLE.
- **Between pulses.** `A`/`B`/`win_dir` hold their values, so the clocked `judgeChessForm` can sample at leisure.
- **Reset** (asynchronous, any time, including mid-scan):
  - state → IDLE, counters cleared;
  - `A`=0, `B`=0, `win_dir`=0, `win_valid`=0, `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0;
  - a partial scan is discarded.

## Timing
- **Cycle numbering.** `start` is sampled in cycle −1; cycle 0 is the first FETCH cycle.
- **Reads.** Slot s drives `rd_addr` in cycle s. `rd_data` is expected in cycle s+1 and is captured at the end of cycle s+1.
- **Window valid.** `win_valid` for direction d is high in cycle 9d+10, i.e. cycles 10, 19, 28, 37.
- **done.** High in cycle 37.
- **busy.** High in cycles 0..37, low from cycle 38.
- **Next start.** May be accepted in cycle 38, giving back-to-back scans of 39 cycles each.
- **Fixed latency.** Off-board slots consume a cycle, so scan time is independent of position.

## Configuration
- Macro: `LINE_WINDOW_EDGE_BLOCK_EN`.
- **Defined:** off-board cells set their bit in `B`, treating the edge as a blocking stone for black-perspective judging; the `A` bit stays 0.
- **Undefined:** off-board cells read as empty, leaving both `A` and `B` bits at 0.
- In both modes no RAM read is issued for off-board cells.

## Test plan
- **Empty board, start (7,7).**
  - Four `win_valid` pulses, in cycles 10/19/28/37.
  - `win_dir` 0..3; `A`=0 and `B`=0 each time.
  - `done` in cycle 37; 36 `rd_en` pulses.
- **Black at (7,5),(7,6),(7,7),(7,8), white at (7,9), start (7,7).**
  - dir0: `A`=9'b000111100, `B`=9'b001000000.
  - dirs 1–3: `A`=9'b000010000, `B`=0.
- **Empty board, start (0,0), macro defined.**
  - dir0 `B`=9'b000001111.
  - dir3 `B`=9'b111101111.
  - `A`=0 throughout.
  - exactly 16 `rd_en` pulses.
- **Same as previous, macro undefined.**
  - All `A`=`B`=0.
  - 16 `rd_en` pulses; `rd_addr` never exceeds 224.
- **Reset in cycle 15 of a scan.**
  - All outputs 0 immediately.
  - No further `win_valid`.
  - A subsequent start (7,7) completes normally with correct windows.
- **Ignored starts.**
  - `start` with `col`=15: `busy` stays 0.
  - Second `start` in cycle 5 of an active scan: ignored; exactly four windows and one `done` are produced.
